// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage.
// One-cycle multiply, 32-step restoring divide, mthi/mtlo/mfhi/mflo access.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             do_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             reg_write,
  input  logic             reg_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             uns_q;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic [CW-1:0]    cnt;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;

  assign busy  = (state != IDLE);
  assign rdata = reg_sel ? lo : hi;

  assign sa    = !do_unsigned && op_a[WIDTH-1];
  assign sb    = !do_unsigned && op_b[WIDTH-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;

  // Low 2W bits of the extended product are exact for both signednesses.
  assign ext_a = uns_q ? {{WIDTH{1'b0}}, a_q}
                       : {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign ext_b = uns_q ? {{WIDTH{1'b0}}, b_q}
                       : {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Extra bit keeps the shifted remainder exact for divisors >= 2^(W-1).
  assign rem_sh   = {rem, quot[WIDTH-1]};
  assign rem_sub  = rem_sh - {1'b0, dvsr};
  assign ge       = !rem_sub[WIDTH];
  assign rem_nxt  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_nxt = {quot[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      uns_q  <= 1'b0;
      quot   <= '0;
      rem    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!op_div) begin
              a_q   <= op_a;
              b_q   <= op_b;
              uns_q <= do_unsigned;
              done  <= 1'b1;
              state <= MUL;
            end else if (op_b != '0) begin
              quot   <= mag_a;
              dvsr   <= mag_b;
              rem    <= '0;
              sign_q <= sa ^ sb;
              sign_r <= sa;
              cnt    <= '0;
              state  <= DIV;
            end else begin
              quot   <= '1;
              rem    <= op_a;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
              done   <= 1'b1;
              state  <= FIX;
            end
          end else if (reg_write) begin
            if (reg_sel) lo <= wdata;
            else         hi <= wdata;
          end
        end
        MUL: begin
          {hi, lo} <= prod;
          state    <= IDLE;
        end
        DIV: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            done  <= 1'b1;
            state <= FIX;
          end
        end
        FIX: begin
          lo    <= sign_q ? -quot : quot;
          hi    <= sign_r ? -rem : rem;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and random checks of hilo_muldiv_unit against
// an arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_div;
  logic        do_unsigned;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        reg_write;
  logic        reg_sel;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_div      (op_div),
    .do_unsigned (do_unsigned),
    .op_a        (op_a),
    .op_b        (op_b),
    .reg_write   (reg_write),
    .reg_sel     (reg_sel),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .rdata       (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic d, input logic u,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (u) return {a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_busy(input logic d, input logic [31:0] b);
    if (d && b != 32'd0) return 33;
    return 1;
  endfunction

  // Issues one op; returns busy-cycle and done-pulse counts.
  // Start stays high for `hold` busy cycles to exercise start-while-busy.
  task automatic run_op(input logic d, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold,
                        output int bc, output int dc);
    @(negedge clk);
    start = 1'b1; op_div = d; do_unsigned = u; op_a = a; op_b = b;
    @(posedge clk); #1;
    if (hold == 0) start = 1'b0;
    bc = 0; dc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (done) dc++;
      if (bc >= hold) start = 1'b0;
      else op_a = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic write_reg(input logic sel, input logic [31:0] v);
    @(negedge clk);
    reg_write = 1'b1; reg_sel = sel; wdata = v;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic d, input logic u,
                          input logic [31:0] a, input logic [31:0] b);
    int bc, dc;
    run_op(d, u, a, b, 0, bc, dc);
    check({tag, " hilo"}, {hi, lo}, ref_op(d, u, a, b));
    check({tag, " busy"}, 64'(bc), 64'(ref_busy(d, b)));
    check({tag, " done"}, 64'(dc), 64'd1);
  endtask

  initial begin
    int bc, dc;
    logic d, u;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op_div = 1'b0; do_unsigned = 1'b0;
    op_a = '0; op_b = '0; reg_write = 1'b0; reg_sel = 1'b0; wdata = '0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hilo", {hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    run_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 0, bc, dc);
    check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult busy", 64'(bc), 64'd1);
    check("mult done", 64'(dc), 64'd1);
    check("mult done low", 64'(done), 64'd0);

    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, bc, dc);
    check("multu const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, bc, dc);
    check("div -7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div busy", 64'(bc), 64'd33);
    check("div done", 64'(dc), 64'd1);

    run_op(1'b1, 1'b1, 32'd100, 32'd7, 0, bc, dc);
    check("divu 100/7", {hi, lo}, {32'd2, 32'd14});

    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, bc, dc);
    check("div ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(1'b1, 1'b0, 32'h1234, 32'd0, 0, bc, dc);
    check("div0", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    check("div0 busy", 64'(bc), 64'd1);
    check("div0 done", 64'(dc), 64'd1);

    write_reg(1'b0, 32'hAAAA_5555);
    write_reg(1'b1, 32'h0F0F_0F0F);
    reg_sel = 1'b0; #1;
    check("mfhi", 64'(rdata), 64'hAAAA_5555);
    reg_sel = 1'b1; #1;
    check("mflo", 64'(rdata), 64'h0F0F_0F0F);

    // mtlo strobe while divide is in flight must be dropped.
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; do_unsigned = 1'b1;
    op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reg_write = 1'b1; reg_sel = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reg_write = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk); #1;
    end
    check("mtlo busy", {hi, lo}, {32'd1, 32'd333});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; do_unsigned = 1'b1;
    op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(1'b0, 1'b0, 32'd6, 32'd7, 0, bc, dc);
    check("post rst mult", {hi, lo}, 64'd42);

    // Start held high through a divide: only the first is accepted.
    run_op(1'b1, 1'b1, 32'd100, 32'd7, 20, bc, dc);
    check("hold hilo", {hi, lo}, {32'd2, 32'd14});
    check("hold busy", 64'(bc), 64'd33);
    check("hold done", 64'(dc), 64'd1);

    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom);
      u = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 17);
        2: b = -($urandom_range(1, 17));
        default: b = $urandom;
      endcase
      op_check($sformatf("rand%0d", i), d, u, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
